// File: rtl/multi_cycle_alu_pkg.sv
// multi_cycle_alu_pkg: ALU operation codes and MD-class helpers
package multi_cycle_alu_pkg;
  typedef logic [4:0] alu_op_t;
  localparam alu_op_t ALU_ADD   = 5'd0;
  localparam alu_op_t ALU_SUB   = 5'd1;
  localparam alu_op_t ALU_OR    = 5'd2;
  localparam alu_op_t ALU_LUI   = 5'd3;
  localparam alu_op_t ALU_AND   = 5'd4;
  localparam alu_op_t ALU_XOR   = 5'd5;
  localparam alu_op_t ALU_NOR   = 5'd6;
  localparam alu_op_t ALU_SLT   = 5'd7;
  localparam alu_op_t ALU_SLTU  = 5'd8;
  localparam alu_op_t ALU_SLL   = 5'd9;
  localparam alu_op_t ALU_SRL   = 5'd10;
  localparam alu_op_t ALU_SRA   = 5'd11;
  localparam alu_op_t ALU_MFHI  = 5'd12;
  localparam alu_op_t ALU_MFLO  = 5'd13;
  localparam alu_op_t ALU_MTHI  = 5'd16;
  localparam alu_op_t ALU_MTLO  = 5'd17;
  localparam alu_op_t ALU_MULT  = 5'd18;
  localparam alu_op_t ALU_MULTU = 5'd19;
  localparam alu_op_t ALU_DIV   = 5'd20;
  localparam alu_op_t ALU_DIVU  = 5'd21;
  function automatic logic is_mul(input alu_op_t op);
    return op == ALU_MULT || op == ALU_MULTU;
  endfunction
  function automatic logic is_long(input alu_op_t op);
    return is_mul(op) || op == ALU_DIV || op == ALU_DIVU;
  endfunction
endpackage

// File: rtl/multi_cycle_alu_if.sv
// multi_cycle_alu_if: operand, control and result bundle of the EX-stage ALU
interface multi_cycle_alu_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0] ALUCtrl;
  logic start;
  logic [WIDTH-1:0] Result;
  logic Zero;
  logic busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  modport master (output A, B, ALUCtrl, start, input Result, Zero, busy, HI, LO);
  modport slave (input A, B, ALUCtrl, start, output Result, Zero, busy, HI, LO);
endinterface

// File: rtl/multi_cycle_alu_md_unit.sv
// md_unit: iterative-latency multiply/divide with HI/LO registers and busy countdown
module md_unit
  import multi_cycle_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t op,
  input  logic start,
  output logic busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXC = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {WIDTH-1{1'b0}}};
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] ra, rb, bd, qs, rs, qu, ru, nhi, nlo;
  logic [2*WIDTH-1:0] prod;
  alu_op_t rop;
  logic sgn, dz, ovf, accept;
  assign busy = cnt != '0;
  assign accept = start && !busy;
  // result from latched operands; divisor forced to 1 for /0 and MIN/-1 so the divider never traps
  always_comb begin
    sgn = rop == ALU_MULT || rop == ALU_DIV;
    prod = {{WIDTH{sgn & ra[WIDTH-1]}}, ra} * {{WIDTH{sgn & rb[WIDTH-1]}}, rb};
    dz = rb == '0;
    ovf = sgn && ra == MIN && rb == '1;
    bd = (dz || ovf) ? WIDTH'(1) : rb;
    qs = $signed(ra) / $signed(bd);
    rs = $signed(ra) % $signed(bd);
    qu = ra / bd;
    ru = ra % bd;
    nlo = is_mul(rop) ? prod[WIDTH-1:0] : dz ? '1 : sgn ? qs : qu;
    nhi = is_mul(rop) ? prod[2*WIDTH-1:WIDTH] : dz ? ra : sgn ? rs : ru;
  end
  // accept, countdown and commit on the edge where the counter reaches zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      ra <= '0;
      rb <= '0;
      rop <= ALU_ADD;
    end else if (accept && is_long(op)) begin
      ra <= a;
      rb <= b;
      rop <= op;
      cnt <= is_mul(op) ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
    end else if (accept && op == ALU_MTHI) begin
      hi <= a;
    end else if (accept && op == ALU_MTLO) begin
      lo <= a;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        hi <= nhi;
        lo <= nlo;
      end
    end
  end
endmodule

// File: rtl/multi_cycle_alu.sv
// multi_cycle_alu: EX-stage ALU with combinational ops and a multi-cycle MD path
module multi_cycle_alu
  import multi_cycle_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  multi_cycle_alu_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  logic [SW-1:0] sh;
  assign sh = bus.A[SW-1:0];
  assign bus.Zero = bus.A == bus.B;
  md_unit #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md (
    .clk(clk),
    .reset(reset),
    .a(bus.A),
    .b(bus.B),
    .op(bus.ALUCtrl),
    .start(bus.start),
    .busy(bus.busy),
    .hi(bus.HI),
    .lo(bus.LO)
  );
  // combinational result select; MFHI/MFLO expose the registers even while busy
  always_comb begin
    case (bus.ALUCtrl)
      ALU_ADD:  bus.Result = bus.A + bus.B;
      ALU_SUB:  bus.Result = bus.A - bus.B;
      ALU_OR:   bus.Result = bus.A | bus.B;
      ALU_AND:  bus.Result = bus.A & bus.B;
      ALU_XOR:  bus.Result = bus.A ^ bus.B;
      ALU_NOR:  bus.Result = ~(bus.A | bus.B);
      ALU_SLT:  bus.Result = {{WIDTH-1{1'b0}}, $signed(bus.A) < $signed(bus.B)};
      ALU_SLTU: bus.Result = {{WIDTH-1{1'b0}}, bus.A < bus.B};
      ALU_LUI:  bus.Result = {bus.B[WIDTH/2-1:0], {WIDTH/2{1'b0}}};
      ALU_SLL:  bus.Result = bus.B << sh;
      ALU_SRL:  bus.Result = bus.B >> sh;
      ALU_SRA:  bus.Result = $signed(bus.B) >>> sh;
      ALU_MFHI: bus.Result = bus.HI;
      ALU_MFLO: bus.Result = bus.LO;
      default:  bus.Result = '0;
    endcase
  end
endmodule

// File: tb/tb_multi_cycle_alu.sv
// tb_multi_cycle_alu: directed checks of combinational ops, MD latency/commit and reset
module tb_multi_cycle_alu;
  import multi_cycle_alu_pkg::*;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int failures = 0;
  multi_cycle_alu_if #(.WIDTH(32)) m32 ();
  multi_cycle_alu_if #(.WIDTH(16)) m16 ();
  multi_cycle_alu #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(m32));
  multi_cycle_alu #(.WIDTH(16), .MUL_CYCLES(3), .DIV_CYCLES(4)) dut16 (.clk(clk), .reset(reset), .bus(m16));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic md32(input alu_op_t op, input logic [31:0] a, input logic [31:0] b, input int n, input string tag);
    m32.ALUCtrl = op; m32.A = a; m32.B = b; m32.start = 1;
    tick();
    m32.start = 0; m32.A = ~a; m32.B = ~b;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, 64'(m32.busy), 64'(1));
      tick();
    end
    chk({tag, "_idle"}, 64'(m32.busy), 64'(0));
  endtask
  task automatic comb(input alu_op_t op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input string tag);
    m32.ALUCtrl = op; m32.A = a; m32.B = b;
    #1;
    chk(tag, 64'(m32.Result), 64'(exp));
  endtask
  initial begin
    m32.A = 0; m32.B = 0; m32.ALUCtrl = ALU_ADD; m32.start = 0;
    m16.A = 0; m16.B = 0; m16.ALUCtrl = ALU_ADD; m16.start = 0;
    tick(); tick();
    reset = 0;
    chk("rst_busy", 64'(m32.busy), 64'(0));
    chk("rst_hi", 64'(m32.HI), 64'(0));
    chk("rst_lo", 64'(m32.LO), 64'(0));
    m32.ALUCtrl = ALU_MULT; m32.A = 32'hFFFF_FFFF; m32.B = 2; m32.start = 1;
    tick();
    m32.start = 0;
    chk("mult_nocommit_early", 64'(m32.LO), 64'(0));
    for (int i = 1; i < 5; i++) tick();
    chk("mult_busy_last", 64'(m32.busy), 64'(1));
    tick();
    chk("mult_idle", 64'(m32.busy), 64'(0));
    chk("mult_hi", 64'(m32.HI), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(m32.LO), 64'hFFFF_FFFE);
    md32(ALU_MULTU, 32'hFFFF_FFFF, 2, 5, "multu");
    chk("multu_hi", 64'(m32.HI), 64'(1));
    chk("multu_lo", 64'(m32.LO), 64'hFFFF_FFFE);
    md32(ALU_DIV, 32'hFFFF_FFF9, 2, 10, "div");
    chk("div_lo", 64'(m32.LO), 64'hFFFF_FFFD);
    chk("div_hi", 64'(m32.HI), 64'hFFFF_FFFF);
    md32(ALU_DIVU, 32'h1234_5678, 0, 10, "divu0");
    chk("divu0_lo", 64'(m32.LO), 64'hFFFF_FFFF);
    chk("divu0_hi", 64'(m32.HI), 64'h1234_5678);
    md32(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, "divovf");
    chk("divovf_lo", 64'(m32.LO), 64'h8000_0000);
    chk("divovf_hi", 64'(m32.HI), 64'(0));
    m32.ALUCtrl = ALU_MULT; m32.A = 3; m32.B = 5; m32.start = 1;
    tick();
    m32.ALUCtrl = ALU_MTLO; m32.A = 5;
    tick();
    m32.ALUCtrl = ALU_MULT; m32.A = 7; m32.B = 7;
    tick();
    m32.start = 0;
    m32.ALUCtrl = ALU_MFLO;
    #1;
    chk("mflo_while_busy", 64'(m32.Result), 64'h8000_0000);
    tick(); tick();
    chk("drop_busy_last", 64'(m32.busy), 64'(1));
    tick();
    chk("drop_idle", 64'(m32.busy), 64'(0));
    chk("drop_lo", 64'(m32.LO), 64'(15));
    chk("drop_hi", 64'(m32.HI), 64'(0));
    m32.ALUCtrl = ALU_MTLO; m32.A = 5; m32.start = 1;
    tick();
    m32.ALUCtrl = ALU_MTHI; m32.A = 9;
    chk("mtlo_lo", 64'(m32.LO), 64'(5));
    chk("mtlo_nobusy", 64'(m32.busy), 64'(0));
    tick();
    m32.start = 0;
    chk("mthi_hi", 64'(m32.HI), 64'(9));
    comb(ALU_MFLO, 0, 0, 5, "mflo");
    comb(ALU_MFHI, 0, 0, 9, "mfhi");
    m32.ALUCtrl = ALU_DIV; m32.A = 100; m32.B = 7; m32.start = 1;
    tick();
    m32.start = 0;
    tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rstdiv_busy", 64'(m32.busy), 64'(0));
    chk("rstdiv_hi", 64'(m32.HI), 64'(0));
    chk("rstdiv_lo", 64'(m32.LO), 64'(0));
    comb(ALU_MFLO, 0, 0, 0, "rstdiv_mflo");
    for (int i = 0; i < 10; i++) tick();
    chk("rstdiv_discard", 64'(m32.HI), 64'(0));
    m32.ALUCtrl = ALU_MULT; m32.A = 3; m32.B = 3; m32.start = 1; reset = 1;
    tick();
    reset = 0; m32.start = 0;
    chk("rst_beats_start", 64'(m32.busy), 64'(0));
    comb(ALU_SRA, 4, 32'h8000_0000, 32'hF800_0000, "sra");
    comb(ALU_SRL, 4, 32'h8000_0000, 32'h0800_0000, "srl");
    comb(ALU_SLL, 32'h24, 1, 32'h10, "sll_mask");
    comb(ALU_SLT, 32'hFFFF_FFFF, 1, 1, "slt");
    comb(ALU_SLTU, 32'hFFFF_FFFF, 1, 0, "sltu");
    comb(ALU_LUI, 0, 32'h1234, 32'h1234_0000, "lui");
    comb(ALU_ADD, 32'hFFFF_FFFF, 1, 0, "add_wrap");
    comb(ALU_SUB, 0, 1, 32'hFFFF_FFFF, "sub_wrap");
    comb(ALU_AND, 32'hF0F0_FF00, 32'hFF00_0FF0, 32'hF000_0F00, "and");
    comb(ALU_OR, 32'hF0F0_FF00, 32'hFF00_0FF0, 32'hFFF0_FFF0, "or");
    comb(ALU_XOR, 32'hF0F0_FF00, 32'hFF00_0FF0, 32'h0FF0_F0F0, "xor");
    comb(ALU_NOR, 32'hF0F0_FF00, 32'hFF00_0FF0, 32'h000F_000F, "nor");
    comb(5'd31, 32'h1234, 32'h5678, 0, "undef");
    chk("zero_ne", 64'(m32.Zero), 64'(0));
    comb(ALU_ADD, 32'hABCD, 32'hABCD, 32'h1579A, "add");
    chk("zero_eq", 64'(m32.Zero), 64'(1));
    m16.ALUCtrl = ALU_MULT; m16.A = 16'h8000; m16.B = 16'h8000; m16.start = 1;
    tick();
    m16.start = 0; m16.A = 16'h1;
    tick(); tick();
    chk("w16_mult_busy_last", 64'(m16.busy), 64'(1));
    tick();
    chk("w16_mult_idle", 64'(m16.busy), 64'(0));
    chk("w16_mult_hi", 64'(m16.HI), 64'h4000);
    chk("w16_mult_lo", 64'(m16.LO), 64'h0000);
    m16.ALUCtrl = ALU_DIV; m16.A = 16'hFFF9; m16.B = 2; m16.start = 1;
    tick();
    m16.start = 0;
    for (int i = 1; i < 4; i++) tick();
    chk("w16_div_busy_last", 64'(m16.busy), 64'(1));
    tick();
    chk("w16_div_lo", 64'(m16.LO), 64'hFFFD);
    chk("w16_div_hi", 64'(m16.HI), 64'hFFFF);
    m16.ALUCtrl = ALU_LUI; m16.B = 16'h0012;
    #1;
    chk("w16_lui", 64'(m16.Result), 64'h1200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
